// File: rtl/divider_control.sv
// Sequencer for the bitslice restoring divider: drives load/shift/accumulate strobes
// from Start, uses datapath nBorrow/nZ feedback, and flags divide-by-zero.
module divider_control #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ITERS = WIDTH + 1
) (
   input  logic Clock,
   input  logic nReset,
   input  logic Start,
   input  logic Abort,
   input  logic nBorrow,
   input  logic nZ,
   output logic Load,
   output logic LoadAcc,
   output logic LoadResult,
   output logic ShiftIn,
   output logic ShiftInDH,
   output logic nBorrowIn,
   output logic nZIn,
   output logic Ready,
   output logic Done,
   output logic DivByZero
);

   localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StCheck = 3'd2,
      StIter  = 3'd3,
      StDone  = 3'd4,
      StError = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic   [CW-1:0] count_q, count_d;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign nBorrowIn = 1'b1;
   assign nZIn      = 1'b1;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      Load       = 1'b0;
      LoadAcc    = 1'b0;
      LoadResult = 1'b0;
      ShiftIn    = 1'b0;
      ShiftInDH  = 1'b0;
      Ready      = 1'b0;
      Done       = 1'b0;
      DivByZero  = 1'b0;
      unique case (state_q)
         StIdle: begin
            Ready = 1'b1;
            if (Start) state_d = StLoad;
         end
         StLoad: begin
            Load    = 1'b1;
            LoadAcc = 1'b1;
            state_d = Abort ? StIdle : StCheck;
         end
         StCheck: begin
            if (Abort) begin
               state_d = StIdle;
            end else if (!nZ) begin
               state_d = StError;
            end else begin
               state_d = StIter;
               count_d = CW'(ITERS - 1);
            end
         end
         StIter: begin
            // Quotient bit and accumulator write follow the live borrow result.
            ShiftInDH = 1'b1;
            ShiftIn   = nBorrow;
            LoadAcc   = nBorrow;
            if (count_q != '0) count_d = count_q - 1'b1;
            if (Abort) begin
               state_d = StIdle;
            end else if (count_q == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            LoadResult = 1'b1;
            Done       = 1'b1;
            state_d    = StIdle;
         end
         StError: begin
            DivByZero = 1'b1;
            Ready     = 1'b1;
            if (Start) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control: a behavioural datapath closes the loop, and results are
// compared with plain integer division.
module tb_divider_control;

   logic Clock, nReset, Start, Abort, nBorrow, nZ;
   logic Load, LoadAcc, LoadResult, ShiftIn, ShiftInDH, nBorrowIn, nZIn;
   logic Ready, Done, DivByZero;

   int checks = 0;
   int errors = 0;

   // Datapath model
   logic [7:0]  op1, op2;
   logic [15:0] acc, dvs;
   logic [8:0]  res;
   logic [7:0]  quotient = 8'd0, remainder = 8'd0;

   assign nBorrow = (acc >= dvs);
   assign nZ      = (dvs != 16'd0);

   always @(posedge Clock) begin
      if (Load) begin
         acc <= {8'd0, op1};
         dvs <= {op2, 8'd0};
         res <= '0;
      end else begin
         if (LoadAcc) acc <= acc - dvs;
         if (ShiftInDH) begin
            dvs <= dvs >> 1;
            res <= {res[7:0], ShiftIn};
         end
         if (LoadResult) begin
            quotient  <= res[7:0];
            remainder <= acc[7:0];
         end
      end
   end

   divider_control dut (
      .Clock(Clock), .nReset(nReset), .Start(Start), .Abort(Abort),
      .nBorrow(nBorrow), .nZ(nZ), .Load(Load), .LoadAcc(LoadAcc),
      .LoadResult(LoadResult), .ShiftIn(ShiftIn), .ShiftInDH(ShiftInDH),
      .nBorrowIn(nBorrowIn), .nZIn(nZIn), .Ready(Ready), .Done(Done),
      .DivByZero(DivByZero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #300000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reset-value vector: {Load,LoadAcc,LoadResult,ShiftIn,ShiftInDH,nBorrowIn,nZIn,Ready,Done,DivByZero}
   function automatic logic [9:0] outs();
      return {Load, LoadAcc, LoadResult, ShiftIn, ShiftInDH, nBorrowIn, nZIn, Ready, Done,
              DivByZero};
   endfunction

   // Call at a negedge with the DUT ready. abort_iter<0 means no abort.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int abort_iter,
                         input bit hold, input bit abort_with_start);
      logic [8:0] q;
      logic [7:0] r, prev_q, prev_r;
      prev_q = quotient;
      prev_r = remainder;
      op1 = a;
      op2 = b;
      Start = 1'b1;
      Abort = abort_with_start;
      @(negedge Clock);
      chk("load", {12'd0, Load, LoadAcc, Ready, DivByZero}, 16'b1100);
      Abort = 1'b0;
      if (!hold) Start = 1'b0;
      @(negedge Clock);
      chk("check", {11'd0, Load, LoadAcc, LoadResult, ShiftInDH, Ready}, 16'd0);
      if (b == 8'd0) begin
         Start = 1'b0;
         @(negedge Clock);
         chk("dbz", {12'd0, DivByZero, Ready, LoadResult, Done}, 16'b1100);
         @(negedge Clock);
         chk("dbz_sticky", {14'd0, DivByZero, Done}, 16'b10);
         chk("dbz_q", {prev_q, prev_r}, {quotient, remainder});
         return;
      end
      q = 9'(a / b);
      r = a % b;
      for (int i = 0; i < 9; i++) begin
         @(negedge Clock);
         chk($sformatf("shiftin%0d", i), {15'd0, ShiftIn}, {15'd0, q[8-i]});
         chk($sformatf("iter%0d", i), {12'd0, ShiftInDH, Load, LoadAcc, Done},
             {12'd0, 1'b1, 1'b0, q[8-i], 1'b0});
         if (i == abort_iter) begin
            Abort = 1'b1;
            Start = 1'b0;
            @(negedge Clock);
            Abort = 1'b0;
            chk("abort_idle", {13'd0, Ready, ShiftInDH, Done}, 16'b100);
            repeat (8) begin
               @(negedge Clock);
               chk("abort_nodone", {14'd0, Done, LoadResult}, 16'd0);
            end
            chk("abort_keep", {quotient, remainder}, {prev_q, prev_r});
            return;
         end
      end
      Start = 1'b0;
      @(negedge Clock);
      chk("done", {12'd0, LoadResult, Done, Ready, ShiftInDH}, 16'b1100);
      @(negedge Clock);
      chk("idle_after", {14'd0, Ready, Done}, 16'b10);
      chk($sformatf("result_%0d_%0d", a, b), {quotient, remainder}, {q[7:0], r});
   endtask

   initial begin
      nReset = 1'b1;
      Start  = 1'b0;
      Abort  = 1'b0;
      op1    = 8'd0;
      op2    = 8'd0;
      #200;
      nReset = 1'b0;
      Start  = 1'b1;
      #1;
      chk("reset", {6'd0, outs()}, 16'b0000011100);
      repeat (4) begin
         @(negedge Clock);
         chk("reset_hold", {6'd0, outs()}, 16'b0000011100);
      end
      Start  = 1'b0;
      nReset = 1'b1;
      @(negedge Clock);

      run_op(8'd9, 8'd8, -1, 1'b0, 1'b0);
      run_op(8'd255, 8'd1, -1, 1'b0, 1'b0);
      run_op(8'd0, 8'd7, -1, 1'b0, 1'b0);
      run_op(8'd7, 8'd9, -1, 1'b0, 1'b0);
      run_op(8'd50, 8'd0, -1, 1'b0, 1'b0);
      run_op(8'd100, 8'd3, -1, 1'b0, 1'b0);
      run_op(8'd200, 8'd13, -1, 1'b1, 1'b0);
      run_op(8'd123, 8'd5, 3, 1'b1, 1'b0);
      run_op(8'd77, 8'd4, -1, 1'b0, 1'b1);

      // Asynchronous reset between edges in the middle of an iteration
      op1 = 8'd90;
      op2 = 8'd7;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (4) @(negedge Clock);
      #2;
      nReset = 1'b0;
      #1;
      chk("async_reset", {6'd0, outs()}, 16'b0000011100);
      @(negedge Clock);
      chk("async_hold", {6'd0, outs()}, 16'b0000011100);
      nReset = 1'b1;
      run_op(8'd90, 8'd7, -1, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_op(a, b, -1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
